fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the 5-stage pipeline.
- Holds its own shadow copy of the EX, MEM and WB destination records, so it needs only ID-stage decode fields as input.
- Produces the EX-stage ALU operand mux selects and the ID/IF stall.
- A mode parameter selects full forwarding or a no-forwarding fallback that stalls on every RAW hazard.
- A saturating stall-cycle counter provides performance visibility.

Parameters:
ADDR_W, 5, register address width
FWD_EN, 1, 1 = forwarding with load-use stall only; 0 = no forwarding, stall on any RAW against EX/MEM
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-low reset
id_valid_i  input  1  ID stage holds a real instruction
id_rs_i  input  ADDR_W  ID source register A
id_rt_i  input  ADDR_W  ID source register B
id_rd_i  input  ADDR_W  ID destination register
id_regwrite_i  input  1  ID instruction writes the register file
id_memread_i  input  1  ID instruction is a load
flush_i  input  1  squash the ID instruction (branch taken)
stall_o  output  1  hold PC and IF/ID; a bubble is inserted into EX
ex_fwd_a_o  output  2  mux select for EX operand A: 10 = MEM result, 01 = WB result, 00 = regfile
ex_fwd_b_o  output  2  same encoding for EX operand B
stall_cnt_o  output  CNT_W  cycles in which stall_o was high, saturating

Behaviour:
Reset (rst_i low, asynchronous):
- EX, MEM and WB records all invalid.
- stall_cnt_o = 0.
- ex_fwd_a_o = ex_fwd_b_o = 00 and stall_o = 0 while reset is held, independent of inputs.

State records:
- EX = {valid, rs, rt, rd, regwrite, memread}
- MEM = {valid, rd, regwrite, memread}
- WB = {valid, rd, regwrite}

Advance, every clock edge:
- WB <= MEM and MEM <= EX, always; the back end never stalls.
- EX <= ID fields with valid = id_valid_i, except EX.valid <= 0 (bubble) when stall_o or flush_i is high.
- flush_i together with stall_o still gives a bubble.

A record "writes r" when valid & regwrite & rd == r & r != 0. Register 0 never forwards and never stalls.

Forwarding (FWD_EN = 1):
- Selects are combinational from the EX/MEM/WB flops only; there is no input-to-output path.
- Operand A: 10 if MEM writes EX.rs and MEM is not a load; else 01 if WB writes EX.rs; else 00. Operand B uses EX.rt identically.
- MEM has priority over WB, so the newest value wins. The two operands are evaluated independently and may both be non-zero in the same cycle.
- With EX invalid, both selects are 00.

Load-use stall (FWD_EN = 1):
- stall_o = id_valid_i & EX.memread & EX writes (id_rs_i or id_rt_i).
- This is combinational and re-evaluated each cycle. It gives exactly 1 bubble, after which the load sits in WB and forwards with select 01.

No-forward mode (FWD_EN = 0):
- ex_fwd_a_o and ex_fwd_b_o are constant 00.
- stall_o = id_valid_i & (EX writes id_rs_i/id_rt_i | MEM writes id_rs_i/id_rt_i).
- The register file writes before it reads, so WB is never a hazard. A dependent instruction therefore stalls up to 2 cycles.

Stall counter:
- Increments on every edge with stall_o = 1.
- Saturates at all-ones with no wrap.
- Cleared only by reset.

Other boundary cases:
- A matching record with regwrite = 0 causes no forward and no stall.
- A load whose rd = 0 never stalls.
- Reset asserted mid-stall drops stall_o immediately and discards all in-flight records.

Test Plan:
- FWD_EN=1, back-to-back `add r3` then `sub r4, r3, r3` -> cycle 2 EX: ex_fwd_a_o = ex_fwd_b_o = 10, stall_o = 0.
- `add r3`, an unrelated instruction, then `or r5, r1, r3` -> or in EX sees ex_fwd_b_o = 01, ex_fwd_a_o = 00.
- `add r3` in WB and `add r3` in MEM, EX reads r3 -> select 10 (MEM priority), not 01.
- `lw r2`, then `and r6, r2, r7` -> stall_o = 1 for exactly 1 cycle, EX bubble (no forward), then and in EX with ex_fwd_a_o = 01; stall_cnt_o goes 0 -> 1.
- FWD_EN=0, `add r3`, then `sub r4, r3, r1` -> stall_o high 2 consecutive cycles, selects stay 00, stall_cnt_o = 2. Same sequence on r0 -> no stall.
- CNT_W=2, 5 forced load-use stalls -> stall_cnt_o saturates at 3. Assert rst_i low during a stall -> stall_o = 0 and counter = 0 asynchronously; a dependent instruction after release sees selects 00.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Forwarding and load-use hazard unit for a 5-stage pipeline.
//                Keeps shadow EX/MEM/WB destination records fed from the ID
//                decode fields, drives the EX operand mux selects and the
//                IF/ID stall, and counts stall cycles (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,          // asynchronous, active low
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic [ADDR_W-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [1:0]        ex_fwd_a_o,
    output logic [1:0]        ex_fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Operand mux select encodings
    localparam logic [1:0]        c_SEL_RF  = 2'b00;
    localparam logic [1:0]        c_SEL_WB  = 2'b01;
    localparam logic [1:0]        c_SEL_MEM = 2'b10;
    localparam logic [ADDR_W-1:0] c_REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;

    // EX record
    logic              r_ex_valid;
    logic [ADDR_W-1:0] r_ex_rs;
    logic [ADDR_W-1:0] r_ex_rt;
    logic [ADDR_W-1:0] r_ex_rd;
    logic              r_ex_regwrite;
    logic              r_ex_memread;
    // MEM record
    logic              r_mem_valid;
    logic [ADDR_W-1:0] r_mem_rd;
    logic              r_mem_regwrite;
    logic              r_mem_memread;
    // WB record
    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_rd;
    logic              r_wb_regwrite;

    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_stall_raw;
    logic              w_stall;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    // A record produces register r only if it is live, writes, and r is not r0
    function automatic logic rec_writes(
        input logic              valid,
        input logic              regwrite,
        input logic [ADDR_W-1:0] rd,
        input logic [ADDR_W-1:0] r
    );
        return valid & regwrite & (rd == r) & (r != c_REG_ZERO);
    endfunction

    generate
        if (FWD_EN != 0) begin : g_fwd
            logic w_mem_wr_a;
            logic w_mem_wr_b;
            logic w_wb_wr_a;
            logic w_wb_wr_b;

            // Operand selects come only from the pipeline flops; MEM beats WB
            always_comb begin
                w_mem_wr_a = rec_writes(r_mem_valid, r_mem_regwrite, r_mem_rd, r_ex_rs) & ~r_mem_memread;
                w_mem_wr_b = rec_writes(r_mem_valid, r_mem_regwrite, r_mem_rd, r_ex_rt) & ~r_mem_memread;
                w_wb_wr_a  = rec_writes(r_wb_valid,  r_wb_regwrite,  r_wb_rd,  r_ex_rs);
                w_wb_wr_b  = rec_writes(r_wb_valid,  r_wb_regwrite,  r_wb_rd,  r_ex_rt);
                w_fwd_a    = c_SEL_RF;
                w_fwd_b    = c_SEL_RF;
                if (r_ex_valid) begin
                    if (w_mem_wr_a)     w_fwd_a = c_SEL_MEM;
                    else if (w_wb_wr_a) w_fwd_a = c_SEL_WB;
                    if (w_mem_wr_b)     w_fwd_b = c_SEL_MEM;
                    else if (w_wb_wr_b) w_fwd_b = c_SEL_WB;
                end
            end

            // Only a load in EX cannot be forwarded in time: one bubble
            always_comb begin
                w_stall_raw = id_valid_i & r_ex_memread &
                              (rec_writes(r_ex_valid, r_ex_regwrite, r_ex_rd, id_rs_i) |
                               rec_writes(r_ex_valid, r_ex_regwrite, r_ex_rd, id_rt_i));
            end
        end else begin : g_nofwd
            logic w_unused;

            assign w_fwd_a = c_SEL_RF;
            assign w_fwd_b = c_SEL_RF;

            // Register file writes before reads, so only EX and MEM producers block ID
            always_comb begin
                w_stall_raw = id_valid_i &
                              (rec_writes(r_ex_valid,  r_ex_regwrite,  r_ex_rd,  id_rs_i) |
                               rec_writes(r_ex_valid,  r_ex_regwrite,  r_ex_rd,  id_rt_i) |
                               rec_writes(r_mem_valid, r_mem_regwrite, r_mem_rd, id_rs_i) |
                               rec_writes(r_mem_valid, r_mem_regwrite, r_mem_rd, id_rt_i));
            end

            // Operand and WB fields only matter when forwarding is enabled
            assign w_unused = ^{r_ex_rs, r_ex_rt, r_ex_memread, r_mem_memread,
                                r_wb_valid, r_wb_rd, r_wb_regwrite};
        end
    endgenerate

    // Outputs are forced idle while reset is held, whatever the ID inputs do
    assign w_stall     = rst_i & w_stall_raw;
    assign stall_o     = w_stall;
    assign ex_fwd_a_o  = rst_i ? w_fwd_a : c_SEL_RF;
    assign ex_fwd_b_o  = rst_i ? w_fwd_b : c_SEL_RF;
    assign stall_cnt_o = r_stall_cnt;

    // Shadow pipeline: back end always advances, EX takes a bubble on stall/flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_regwrite  <= 1'b0;
        end else begin
            r_wb_valid     <= r_mem_valid;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memread  <= r_ex_memread;
            r_ex_valid     <= id_valid_i & ~w_stall & ~flush_i;
            r_ex_rs        <= id_rs_i;
            r_ex_rt        <= id_rt_i;
            r_ex_rd        <= id_rd_i;
            r_ex_regwrite  <= id_regwrite_i;
            r_ex_memread   <= id_memread_i;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Scoreboard bench for fwd_hazard_unit. Three instances share
//                one stimulus stream: forwarding, no-forwarding, and
//                forwarding with a 2-bit stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct packed {
        logic        stall;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] cnt;
    } exp_t;

    typedef exp_t [2:0] exp3_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_rw, id_mr, flush;

    logic        stall0, stall1, stall2;
    logic [1:0]  fa0, fa1, fa2, fb0, fb1, fb2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: the instruction occupying each back-end stage
    ins_t  m_ex[3], m_mem[3], m_wb[3];
    int    m_cnt[3];
    int    c_fwd_en[3] = '{1, 0, 1};
    int    c_cmax[3]   = '{65535, 65535, 3};
    exp3_t sbq[$];

    fwd_hazard_unit #(.ADDR_W(5), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
        .id_rt_i(id_rt), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
        .id_memread_i(id_mr), .flush_i(flush), .stall_o(stall0),
        .ex_fwd_a_o(fa0), .ex_fwd_b_o(fb0), .stall_cnt_o(cnt0));

    fwd_hazard_unit #(.ADDR_W(5), .FWD_EN(0), .CNT_W(16)) u_nofwd (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
        .id_rt_i(id_rt), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
        .id_memread_i(id_mr), .flush_i(flush), .stall_o(stall1),
        .ex_fwd_a_o(fa1), .ex_fwd_b_o(fb1), .stall_cnt_o(cnt1));

    fwd_hazard_unit #(.ADDR_W(5), .FWD_EN(1), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
        .id_rt_i(id_rt), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
        .id_memread_i(id_mr), .flush_i(flush), .stall_o(stall2),
        .ex_fwd_a_o(fa2), .ex_fwd_b_o(fb2), .stall_cnt_o(cnt2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t actual(int k);
        exp_t r;
        case (k)
            0:       r = '{stall: stall0, a: fa0, b: fb0, cnt: cnt0};
            1:       r = '{stall: stall1, a: fa1, b: fb1, cnt: cnt1};
            default: r = '{stall: stall2, a: fa2, b: fb2, cnt: {14'd0, cnt2}};
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int k, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, expv, $time);
        end
    endtask

    // Does this stage's instruction produce register r for a later reader?
    function automatic bit produces(ins_t s, logic [4:0] r);
        return s.v && s.rw && (s.rd == r) && (r != 5'd0);
    endfunction

    function automatic exp_t predict(int k, ins_t id);
        exp_t e;
        e.a = 2'd0;
        e.b = 2'd0;
        e.cnt = 16'(m_cnt[k]);
        if (c_fwd_en[k] != 0) begin
            if (m_ex[k].v) begin
                if (produces(m_mem[k], m_ex[k].rs) && !m_mem[k].mr) e.a = 2'd2;
                else if (produces(m_wb[k], m_ex[k].rs))             e.a = 2'd1;
                if (produces(m_mem[k], m_ex[k].rt) && !m_mem[k].mr) e.b = 2'd2;
                else if (produces(m_wb[k], m_ex[k].rt))             e.b = 2'd1;
            end
            e.stall = id.v && m_ex[k].mr &&
                      (produces(m_ex[k], id.rs) || produces(m_ex[k], id.rt));
        end else begin
            e.stall = id.v && (produces(m_ex[k], id.rs) || produces(m_ex[k], id.rt) ||
                               produces(m_mem[k], id.rs) || produces(m_mem[k], id.rt));
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_cnt[k] = 0;
        end
    endtask

    // One ID cycle: drive, record expectations, then step the reference across the edge
    task automatic issue(input logic v, input int rs, input int rt, input int rd,
                         input logic rw, input logic mr, input logic fl);
        ins_t  id;
        exp3_t e3;
        id = '{v: v, rs: rs[4:0], rt: rt[4:0], rd: rd[4:0], rw: rw, mr: mr};
        id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_rd = rd[4:0];
        id_rw = rw; id_mr = mr; flush = fl;
        for (int k = 0; k < 3; k++) e3[k] = predict(k, id);
        sbq.push_back(e3);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_wb[k]  = m_mem[k];
            m_mem[k] = m_ex[k];
            m_ex[k]  = id;
            if (e3[k].stall || fl) m_ex[k].v = 1'b0;
            if (e3[k].stall && m_cnt[k] < c_cmax[k]) m_cnt[k]++;
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUTs present outputs; compare against the oldest expectation
    always @(negedge clk) begin
        exp3_t e3;
        exp_t  act;
        if (sbq.size() > 0) begin
            e3 = sbq.pop_front();
            for (int k = 0; k < 3; k++) begin
                act = actual(k);
                check("stall", k, int'(act.stall), int'(e3[k].stall));
                check("fwd_a", k, int'(act.a),     int'(e3[k].a));
                check("fwd_b", k, int'(act.b),     int'(e3[k].b));
                check("cnt",   k, int'(act.cnt),   int'(e3[k].cnt));
            end
        end
    end

    initial begin
        exp_t act;
        // Reset with hazardous-looking inputs present
        rst_n = 1'b0;
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd3; id_rd = 5'd3;
        id_rw = 1'b1; id_mr = 1'b1; flush = 1'b0;
        model_clear();
        #3;
        for (int k = 0; k < 3; k++) begin
            act = actual(k);
            check("rst_stall", k, int'(act.stall), 0);
            check("rst_fwd_a", k, int'(act.a), 0);
            check("rst_fwd_b", k, int'(act.b), 0);
            check("rst_cnt",   k, int'(act.cnt), 0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 id_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add r3 ; sub r4,r3,r3
        issue(1, 1, 2, 3, 1, 0, 0);
        issue(1, 3, 3, 4, 1, 0, 0);
        nops(3);
        // add r3 ; unrelated ; or r5,r1,r3
        issue(1, 1, 2, 3, 1, 0, 0);
        issue(1, 1, 2, 7, 1, 0, 0);
        issue(1, 1, 3, 5, 1, 0, 0);
        nops(3);
        // add r3 ; add r3 ; reader of r3 -> MEM wins
        issue(1, 1, 2, 3, 1, 0, 0);
        issue(1, 4, 5, 3, 1, 0, 0);
        issue(1, 3, 3, 8, 1, 0, 0);
        nops(3);
        // lw r2 ; and r6,r2,r7 (held while stalled)
        issue(1, 1, 0, 2, 1, 1, 0);
        issue(1, 2, 7, 6, 1, 0, 0);
        issue(1, 2, 7, 6, 1, 0, 0);
        issue(1, 2, 7, 6, 1, 0, 0);
        nops(3);
        // load into r0 never stalls
        issue(1, 1, 0, 0, 1, 1, 0);
        issue(1, 0, 0, 6, 1, 0, 0);
        nops(3);
        // add r3 ; sub r4,r3,r1 held (two stalls without forwarding)
        issue(1, 1, 2, 3, 1, 0, 0);
        repeat (3) issue(1, 3, 1, 4, 1, 0, 0);
        nops(3);
        // same on r0
        issue(1, 1, 2, 0, 1, 0, 0);
        issue(1, 0, 1, 4, 1, 0, 0);
        nops(3);
        // matching producer with regwrite=0
        issue(1, 1, 2, 3, 0, 1, 0);
        issue(1, 3, 3, 4, 1, 0, 0);
        nops(3);
        // flush together with stall
        issue(1, 1, 0, 2, 1, 1, 0);
        issue(1, 2, 2, 6, 1, 0, 1);
        nops(3);
        // several load-use stalls to saturate the 2-bit counter
        repeat (5) begin
            issue(1, 1, 0, 2, 1, 1, 0);
            issue(1, 2, 0, 6, 1, 0, 0);
            nops(2);
        end

        // Reset asserted in the middle of a load-use stall
        issue(1, 1, 0, 2, 1, 1, 0);
        id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd7; id_rd = 5'd6;
        id_rw = 1'b1; id_mr = 1'b0; flush = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) check("pre_rst_stall", k, int'(actual(k).stall), 1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            act = actual(k);
            check("async_rst_stall", k, int'(act.stall), 0);
            check("async_rst_cnt",   k, int'(act.cnt), 0);
            check("async_rst_fwd_a", k, int'(act.a), 0);
            check("async_rst_fwd_b", k, int'(act.b), 0);
        end
        model_clear();
        @(posedge clk);
        #1 id_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 2, 7, 6, 1, 0, 0);
        nops(3);

        // Randomised traffic over a small register set for dense hazards
        for (int i = 0; i < 600; i++) begin
            issue(($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0));
        end
        nops(3);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 0, sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
